// File: rtl/sys_ctrl_if.sv
// Bus bundle between the command sequencer and its environment.
// The environment is the RX deserializer, register file, ALU and TX FIFO.
interface sys_ctrl_if #(
    parameter int width  = 8,
    parameter int ADDR_W = 4
);
    logic [width-1:0]   RX_P_DATA;
    logic               RX_D_VLD;
    logic [width-1:0]   RdData;
    logic               RdData_Valid;
    logic [2*width-1:0] ALU_OUT;
    logic               OUT_Valid;
    logic               FIFO_FULL;
    logic [ADDR_W-1:0]  Address;
    logic               WrEn;
    logic               RdEn;
    logic [width-1:0]   WrData;
    logic               ALU_EN;
    logic [3:0]         ALU_FUN;
    logic               CLK_EN;
    logic [width-1:0]   TX_DATA;
    logic               TX_WR;

    modport master (
        input  RX_P_DATA, RX_D_VLD, RdData, RdData_Valid, ALU_OUT, OUT_Valid, FIFO_FULL,
        output Address, WrEn, RdEn, WrData, ALU_EN, ALU_FUN, CLK_EN, TX_DATA, TX_WR
    );

    modport slave (
        output RX_P_DATA, RX_D_VLD, RdData, RdData_Valid, ALU_OUT, OUT_Valid, FIFO_FULL,
        input  Address, WrEn, RdEn, WrData, ALU_EN, ALU_FUN, CLK_EN, TX_DATA, TX_WR
    );
endinterface

// File: rtl/sys_ctrl.sv
// Command sequencer: parses RX byte frames into register-file and ALU operations.
// It returns read data and ALU results byte-wise to the TX FIFO. Every output is registered.
module sys_ctrl #(
    parameter int width    = 8,
    parameter int ADDR_W   = 4,
    parameter int OPA_ADDR = 0,
    parameter int OPB_ADDR = 1
) (
    input  logic         CLK,
    input  logic         RST,
    sys_ctrl_if.master   bus
);
    localparam logic [width-1:0] CMD_WR     = width'(8'hAA);
    localparam logic [width-1:0] CMD_RD     = width'(8'hBB);
    localparam logic [width-1:0] CMD_ALU_OP = width'(8'hCC);
    localparam logic [width-1:0] CMD_ALU_NP = width'(8'hDD);
    localparam logic [ADDR_W-1:0] OPA_IDX   = ADDR_W'(OPA_ADDR);
    localparam logic [ADDR_W-1:0] OPB_IDX   = ADDR_W'(OPB_ADDR);

    typedef enum logic [3:0] {
        IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B,
        ALU_FUNC, ALU_WAIT, TX_LO, TX_HI, TX_RD
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [ADDR_W-1:0]  address_q, address_d;
    logic [width-1:0]   wrdata_q, wrdata_d;
    logic [width-1:0]   rdbyte_q, rdbyte_d;
    logic [2*width-1:0] result_q, result_d;
    logic [width-1:0]   txdata_q, txdata_d;
    logic [3:0]         alufun_q, alufun_d;
    logic               wren_q, wren_d;
    logic               rden_q, rden_d;
    logic               aluen_q, aluen_d;
    logic               clken_q, clken_d;
    logic               txwr_q, txwr_d;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        address_d = address_q;
        wrdata_d  = wrdata_q;
        rdbyte_d  = rdbyte_q;
        result_d  = result_q;
        txdata_d  = txdata_q;
        alufun_d  = alufun_q;
        wren_d    = 1'b0;
        rden_d    = 1'b0;
        aluen_d   = 1'b0;
        clken_d   = 1'b0;
        txwr_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.RX_D_VLD) begin
                    case (bus.RX_P_DATA)
                        CMD_WR:     state_d = WR_ADDR;
                        CMD_RD:     state_d = RD_ADDR;
                        CMD_ALU_OP: state_d = OP_A;
                        CMD_ALU_NP: state_d = ALU_FUNC;
                        default:    state_d = IDLE;
                    endcase
                end
            end
            WR_ADDR: begin
                if (bus.RX_D_VLD) begin
                    addr_d  = bus.RX_P_DATA[ADDR_W-1:0];
                    state_d = WR_DATA;
                end
            end
            WR_DATA: begin
                if (bus.RX_D_VLD) begin
                    wren_d    = 1'b1;
                    address_d = addr_q;
                    wrdata_d  = bus.RX_P_DATA;
                    state_d   = IDLE;
                end
            end
            RD_ADDR: begin
                if (bus.RX_D_VLD) begin
                    rden_d    = 1'b1;
                    address_d = bus.RX_P_DATA[ADDR_W-1:0];
                    state_d   = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (bus.RdData_Valid) begin
                    rdbyte_d = bus.RdData;
                    state_d  = TX_RD;
                end
            end
            OP_A: begin
                if (bus.RX_D_VLD) begin
                    wren_d    = 1'b1;
                    address_d = OPA_IDX;
                    wrdata_d  = bus.RX_P_DATA;
                    state_d   = OP_B;
                end
            end
            OP_B: begin
                if (bus.RX_D_VLD) begin
                    wren_d    = 1'b1;
                    address_d = OPB_IDX;
                    wrdata_d  = bus.RX_P_DATA;
                    state_d   = ALU_FUNC;
                end
            end
            ALU_FUNC: begin
                if (bus.RX_D_VLD) begin
                    alufun_d = bus.RX_P_DATA[3:0];
                    aluen_d  = 1'b1;
                    clken_d  = 1'b1;
                    state_d  = ALU_WAIT;
                end
            end
            // The gated ALU clock stays on until the result strobe is consumed
            ALU_WAIT: begin
                if (bus.OUT_Valid) begin
                    result_d = bus.ALU_OUT;
                    state_d  = TX_LO;
                end else begin
                    clken_d  = 1'b1;
                end
            end
            TX_LO: begin
                if (!bus.FIFO_FULL) begin
                    txdata_d = result_q[width-1:0];
                    txwr_d   = 1'b1;
                    state_d  = TX_HI;
                end
            end
            TX_HI: begin
                if (!bus.FIFO_FULL) begin
                    txdata_d = result_q[2*width-1:width];
                    txwr_d   = 1'b1;
                    state_d  = IDLE;
                end
            end
            TX_RD: begin
                if (!bus.FIFO_FULL) begin
                    txdata_d = rdbyte_q;
                    txwr_d   = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            address_q <= '0;
            wrdata_q  <= '0;
            rdbyte_q  <= '0;
            result_q  <= '0;
            txdata_q  <= '0;
            alufun_q  <= '0;
            wren_q    <= 1'b0;
            rden_q    <= 1'b0;
            aluen_q   <= 1'b0;
            clken_q   <= 1'b0;
            txwr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            address_q <= address_d;
            wrdata_q  <= wrdata_d;
            rdbyte_q  <= rdbyte_d;
            result_q  <= result_d;
            txdata_q  <= txdata_d;
            alufun_q  <= alufun_d;
            wren_q    <= wren_d;
            rden_q    <= rden_d;
            aluen_q   <= aluen_d;
            clken_q   <= clken_d;
            txwr_q    <= txwr_d;
        end
    end

    assign bus.Address = address_q;
    assign bus.WrEn    = wren_q;
    assign bus.RdEn    = rden_q;
    assign bus.WrData  = wrdata_q;
    assign bus.ALU_EN  = aluen_q;
    assign bus.ALU_FUN = alufun_q;
    assign bus.CLK_EN  = clken_q;
    assign bus.TX_DATA = txdata_q;
    assign bus.TX_WR   = txwr_q;
endmodule

// File: tb/tb_sys_ctrl.sv
// Bench for sys_ctrl: the register file and ALU are modelled as responders.
// Expected traffic comes from a frame-level model of the command protocol.
module tb_sys_ctrl;
    localparam int W  = 8;
    localparam int AW = 4;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    sys_ctrl_if #(.width(W), .ADDR_W(AW)) bus ();

    sys_ctrl #(.width(W), .ADDR_W(AW), .OPA_ADDR(0), .OPB_ADDR(1)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int total = 0, bad = 0, cyc = 0;
    int wr_q[$], wr_c[$], rd_q[$], rd_c[$], alu_q[$], alu_c[$], tx_q[$], tx_c[$];
    logic [7:0] mem [16];
    logic [7:0] ref_mem [16];
    int full_viol = 0, excl_viol = 0, clken_err = 0;
    bit inflight = 1'b0;
    bit rand_full = 1'b0;
    int alu_cnt = 0, ov_delay = 1;
    logic [3:0] fun_s;

    function automatic logic [15:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
        case (f)
            4'd0:    return 16'(a) + 16'(b);
            4'd1:    return 16'(a) - 16'(b);
            4'd2:    return 16'(a) * 16'(b);
            4'd3:    return {8'h00, a & b};
            4'd4:    return {8'h00, a | b};
            default: return {a, b} ^ 16'h5AC3;
        endcase
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cmp(input string tag, input int act[$], input int exp[$]);
        check({tag, "_count"}, act.size(), exp.size());
        for (int i = 0; i < act.size() && i < exp.size(); i++)
            check(tag, act[i], exp[i]);
    endtask

    task automatic clear_logs();
        wr_q.delete(); wr_c.delete(); rd_q.delete(); rd_c.delete();
        alu_q.delete(); alu_c.delete(); tx_q.delete(); tx_c.delete();
    endtask

    // One cycle: sample DUT at negedge, log its traffic, then play regfile/ALU/FIFO.
    task automatic tick();
        @(negedge CLK);
        cyc++;
        if (bus.TX_WR && bus.FIFO_FULL) full_viol++;
        if (bus.WrEn && bus.RdEn) excl_viol++;
        if (bus.OUT_Valid) inflight = 1'b0;
        if (bus.ALU_EN) inflight = 1'b1;
        if (bus.CLK_EN !== inflight) clken_err++;
        if (bus.WrEn) begin
            wr_q.push_back(int'({bus.Address, bus.WrData})); wr_c.push_back(cyc);
            mem[bus.Address] = bus.WrData;
        end
        if (bus.RdEn)   begin rd_q.push_back(int'(bus.Address)); rd_c.push_back(cyc); end
        if (bus.ALU_EN) begin alu_q.push_back(int'(bus.ALU_FUN)); alu_c.push_back(cyc); end
        if (bus.TX_WR)  begin tx_q.push_back(int'(bus.TX_DATA)); tx_c.push_back(cyc); end
        bus.RdData_Valid = 1'b0;
        bus.OUT_Valid    = 1'b0;
        if (bus.RdEn) begin
            bus.RdData       = mem[bus.Address];
            bus.RdData_Valid = 1'b1;
        end
        if (bus.ALU_EN) begin
            alu_cnt = ov_delay;
            fun_s   = bus.ALU_FUN;
        end else if (alu_cnt > 0) begin
            alu_cnt--;
            if (alu_cnt == 0) begin
                bus.ALU_OUT   = alu_f(mem[0], mem[1], fun_s);
                bus.OUT_Valid = 1'b1;
            end
        end
        if (rand_full) bus.FIFO_FULL = ($urandom_range(0, 2) == 0);
    endtask

    task automatic send(input logic [7:0] b, input int gap, output int bcyc);
        bus.RX_P_DATA = b;
        bus.RX_D_VLD  = 1'b1;
        tick();
        bcyc = cyc;
        bus.RX_D_VLD  = 1'b0;
        bus.RX_P_DATA = 8'($urandom);
        repeat (gap) tick();
    endtask

    task automatic wait_done(input int n);
        int t = 0;
        while (tx_q.size() < n && t < 80) begin tick(); t++; end
        repeat (3) tick();
    endtask

    // kind: 0 write, 1 read, 2 ALU with operands, 3 ALU without operands
    task automatic run_frame(input int kind, input logic [7:0] p0, input logic [7:0] p1,
                             input logic [7:0] p2, input bit inj, input bit hold);
        int exp_wr[$], exp_rd[$], exp_alu[$], exp_tx[$];
        int bc, dummy;
        logic [15:0] r;
        logic [3:0] a;
        bit lat;
        lat = !hold && !rand_full;
        a = p0[3:0];
        clear_logs();
        if (hold) bus.FIFO_FULL = 1'b1;
        case (kind)
            0: begin
                send(8'hAA, $urandom_range(0, 2), dummy);
                send(p0, $urandom_range(0, 2), dummy);
                send(p1, 0, bc);
                exp_wr.push_back(int'({a, p1}));
                ref_mem[a] = p1;
            end
            1: begin
                send(8'hBB, $urandom_range(0, 2), dummy);
                send(p0, 0, bc);
                exp_rd.push_back(int'(a));
                exp_tx.push_back(int'(ref_mem[a]));
            end
            2: begin
                send(8'hCC, $urandom_range(0, 2), dummy);
                send(p0, $urandom_range(0, 2), dummy);
                send(p1, $urandom_range(0, 2), dummy);
                send(p2, 0, bc);
                exp_wr.push_back(int'({4'd0, p0}));
                exp_wr.push_back(int'({4'd1, p1}));
                ref_mem[0] = p0;
                ref_mem[1] = p1;
            end
            default: begin
                send(8'hDD, $urandom_range(0, 2), dummy);
                send(p2, 0, bc);
            end
        endcase
        if (kind >= 2) begin
            r = alu_f(ref_mem[0], ref_mem[1], p2[3:0]);
            exp_alu.push_back(int'(p2[3:0]));
            exp_tx.push_back(int'(r[7:0]));
            exp_tx.push_back(int'(r[15:8]));
        end
        if (inj) send(8'($urandom), 0, dummy);
        if (hold) begin
            repeat (ov_delay + 6) tick();
            check("full_stall_no_tx", tx_q.size(), 0);
            bus.FIFO_FULL = 1'b0;
        end
        wait_done(exp_tx.size());
        rand_full = 1'b0;
        bus.FIFO_FULL = 1'b0;
        cmp("wr", wr_q, exp_wr);
        cmp("rd", rd_q, exp_rd);
        cmp("alu_fun", alu_q, exp_alu);
        cmp("tx", tx_q, exp_tx);
        if (lat && kind == 0 && wr_c.size() > 0) check("wr_latency", wr_c[0] - bc, 0);
        if (lat && kind == 1 && rd_c.size() > 0) check("rd_latency", rd_c[0] - bc, 0);
        if (lat && kind == 1 && tx_c.size() > 0) check("rd_tx_latency", tx_c[0] - bc, 2);
        if (lat && kind >= 2 && alu_c.size() > 0) check("alu_latency", alu_c[0] - bc, 0);
    endtask

    initial begin
        int dummy;
        logic [7:0] b;
        for (int i = 0; i < 16; i++) begin mem[i] = 8'h00; ref_mem[i] = 8'h00; end
        fun_s = 4'd0;

        // reset with random inputs applied
        RST = 1'b1;
        #2 RST = 1'b0;
        bus.RX_P_DATA = 8'($urandom); bus.RX_D_VLD = 1'b1;
        bus.RdData = 8'($urandom); bus.RdData_Valid = 1'b1;
        bus.ALU_OUT = 16'($urandom); bus.OUT_Valid = 1'b1;
        bus.FIFO_FULL = 1'($urandom);
        repeat (3) @(negedge CLK);
        check("rst_Address", int'(bus.Address), 0);
        check("rst_WrEn", int'(bus.WrEn), 0);
        check("rst_RdEn", int'(bus.RdEn), 0);
        check("rst_WrData", int'(bus.WrData), 0);
        check("rst_ALU_EN", int'(bus.ALU_EN), 0);
        check("rst_ALU_FUN", int'(bus.ALU_FUN), 0);
        check("rst_CLK_EN", int'(bus.CLK_EN), 0);
        check("rst_TX_DATA", int'(bus.TX_DATA), 0);
        check("rst_TX_WR", int'(bus.TX_WR), 0);
        bus.RX_D_VLD = 1'b0; bus.RdData_Valid = 1'b0; bus.OUT_Valid = 1'b0; bus.FIFO_FULL = 1'b0;
        RST = 1'b1;
        tick();

        // non-command bytes in IDLE are ignored
        clear_logs();
        send(8'h55, 0, dummy);
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom);
            if (b == 8'hAA || b == 8'hBB || b == 8'hCC || b == 8'hDD) b = 8'h12;
            send(b, $urandom_range(0, 1), dummy);
        end
        repeat (4) tick();
        check("stray_wr", wr_q.size(), 0);
        check("stray_rd", rd_q.size(), 0);
        check("stray_alu", alu_q.size(), 0);
        check("stray_tx", tx_q.size(), 0);

        // directed frames
        ov_delay = 1;
        run_frame(0, 8'h05, 8'h3C, 8'h00, 1'b0, 1'b0);
        run_frame(1, 8'h05, 8'h00, 8'h00, 1'b0, 1'b0);
        run_frame(2, 8'h0A, 8'h03, 8'h00, 1'b1, 1'b0);
        check("clk_en_track_cc", clken_err, 0);
        run_frame(3, 8'h00, 8'h00, 8'h02, 1'b0, 1'b1);

        // reset between address and data byte abandons the write
        clear_logs();
        send(8'hAA, 0, dummy);
        send(8'h03, 0, dummy);
        RST = 1'b0;
        inflight = 1'b0;
        alu_cnt = 0;
        bus.RX_P_DATA = 8'h77; bus.RX_D_VLD = 1'b1;
        repeat (2) tick();
        bus.RX_D_VLD = 1'b0;
        RST = 1'b1;
        send(8'h3C, 0, dummy);
        repeat (4) tick();
        check("midframe_rst_no_wr", wr_q.size(), 0);
        check("midframe_rst_CLK_EN", int'(bus.CLK_EN), 0);
        run_frame(0, 8'h01, 8'hFF, 8'h00, 1'b0, 1'b0);

        // randomized frames
        for (int i = 0; i < 40; i++) begin
            int kind;
            kind = $urandom_range(0, 3);
            ov_delay = $urandom_range(1, 4);
            rand_full = ($urandom_range(0, 3) == 0);
            run_frame(kind, 8'($urandom), 8'($urandom), 8'($urandom),
                      (kind != 0) && ($urandom_range(0, 1) == 1), 1'b0);
        end

        check("tx_wr_while_full", full_viol, 0);
        check("wren_rden_overlap", excl_viol, 0);
        check("clk_en_track", clken_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
